// File: rtl/fft_8p_frame_loader.sv
// fft_8p_frame_loader
//   Collects a serial stream of complex samples into N-sample frames held in a
//   two-bank (ping-pong) buffer and presents each complete frame in parallel,
//   natural order, to the FFT core. Frames closed early by s_last are zero-padded.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   s_valid       input sample valid
//   s_ready       loader can accept a sample (depends on registered state only)
//   s_real/imag   signed sample parts, stored bit-exact
//   s_last        sample closes the current frame
//   frame_valid   a complete frame is presented
//   frame_ready   consumer takes the presented frame
//   frame_real/imag  frame contents, index k = k-th accepted sample
//   frame_len     number of real samples in the presented frame (1..N)
//   frame_padded  presented frame was closed early
module fft_8p_frame_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DATA_WIDTH-1:0]            s_real,
  input  logic [DATA_WIDTH-1:0]            s_imag,
  input  logic                             s_last,
  output logic                             frame_valid,
  input  logic                             frame_ready,
  output logic [N-1:0][DATA_WIDTH-1:0]     frame_real,
  output logic [N-1:0][DATA_WIDTH-1:0]     frame_imag,
  output logic [$clog2(N):0]               frame_len,
  output logic                             frame_padded
);

  localparam int CW = $clog2(N);
  localparam int LW = CW + 1;

  logic [N-1:0][DATA_WIDTH-1:0] bank_real [2];
  logic [N-1:0][DATA_WIDTH-1:0] bank_imag [2];
  logic [LW-1:0]                bank_len  [2];
  logic [1:0]                   full;
  logic [1:0]                   padded;
  logic                         wr_sel;
  logic                         rd_sel;
  logic [CW-1:0]                cnt;

  logic accept;
  logic close;
  logic rel_en;

  assign s_ready = ~full[wr_sel];
  assign accept  = s_valid & s_ready;
  assign close   = accept & (s_last | (cnt == CW'(N - 1)));
  assign rel_en  = full[rd_sel] & frame_ready;

  assign frame_valid  = full[rd_sel];
  assign frame_real   = bank_real[rd_sel];
  assign frame_imag   = bank_imag[rd_sel];
  assign frame_len    = bank_len[rd_sel];
  assign frame_padded = padded[rd_sel];

  // The write bank is never full and the release bank always is, so the
  // release and the sample write below never touch the same bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        bank_real[b] <= '0;
        bank_imag[b] <= '0;
        bank_len[b]  <= '0;
      end
      full   <= '0;
      padded <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      cnt    <= '0;
    end else begin
      if (rel_en) begin
        // Zeroing on release is what makes the tail of a short frame read as 0.
        bank_real[rd_sel] <= '0;
        bank_imag[rd_sel] <= '0;
        bank_len[rd_sel]  <= '0;
        full[rd_sel]      <= 1'b0;
        padded[rd_sel]    <= 1'b0;
        rd_sel            <= ~rd_sel;
      end
      if (accept) begin
        bank_real[wr_sel][cnt] <= s_real;
        bank_imag[wr_sel][cnt] <= s_imag;
        if (close) begin
          full[wr_sel]     <= 1'b1;
          bank_len[wr_sel] <= LW'(cnt) + LW'(1);
          padded[wr_sel]   <= (cnt != CW'(N - 1));
          cnt              <= '0;
          wr_sel           <= ~wr_sel;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
